// File: rtl/sync_timing_rx.sv
// sync_timing_rx: recovers pixel position (H, V) from hsync/vsync/de and
// measures the incoming video timing (line length, frame height, active
// width/height). A three-state tracker declares lock once two consecutive
// frames measure identically.
// Optional feature: define SYNC_TIMING_RX_TIMEOUT_EN to add a de watchdog
// that drops lock and restarts the search when de stops toggling.
module sync_timing_rx #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              de,
    output logic [DATA_W-1:0] H,
    output logic [DATA_W-1:0] V,
    output logic [DATA_W-1:0] h_total,
    output logic [DATA_W-1:0] v_total,
    output logic [DATA_W-1:0] h_active,
    output logic [DATA_W-1:0] v_active,
    output logic              line_start,
    output logic              frame_start,
    output logic              locked
);

    localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] ZERO = '0;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] x);
        return (&x) ? x : x + ONE;
    endfunction

    logic s_hs, s_vs, s_de;
    logic s_hs_d, s_vs_d, s_de_d;
    logic de_rise, de_fall, hs_fall, vs_fall;

    logic              vs_pend;
    logic              seen_rise;
    logic [DATA_W-1:0] hcnt, hact_cnt, hs_cnt, dr_cnt;
    logic [DATA_W-1:0] vt_new;
    logic [DATA_W-1:0] snap_ht, snap_vt, snap_ha, snap_va;
    logic              frame_match;
    logic              timeout;
    state_t            state;

    assign de_rise =  s_de & ~s_de_d;
    assign de_fall = ~s_de &  s_de_d;
    assign hs_fall = ~s_hs &  s_hs_d;
    assign vs_fall = ~s_vs &  s_vs_d;

    // Line count of the frame closing now, including a coincident hsync edge.
    assign vt_new = hs_fall ? sat_inc(hs_cnt) : hs_cnt;

    // A de_rise landing on the closing vsync edge belongs to the new frame,
    // so the active-line count of the closing frame is dr_cnt as it stands.
    assign frame_match = (h_total == snap_ht) && (vt_new == snap_vt) &&
                         (h_active == snap_ha) && (dr_cnt == snap_va);

    // Input register plus one cycle of history; idle levels avoid false edges after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_hs   <= 1'b1;
            s_hs_d <= 1'b1;
            s_vs   <= 1'b1;
            s_vs_d <= 1'b1;
            s_de   <= 1'b0;
            s_de_d <= 1'b0;
        end else begin
            s_hs   <= hsync;
            s_vs   <= vsync;
            s_de   <= de;
            s_hs_d <= s_hs;
            s_vs_d <= s_vs;
            s_de_d <= s_de;
        end
    end

    // Position counters; a vsync edge seen on or before de_rise restarts V at line 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            H           <= ZERO;
            V           <= ZERO;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vs_pend     <= 1'b0;
        end else begin
            line_start  <= de_rise;
            frame_start <= de_rise & (vs_pend | vs_fall);
            if (de_rise) begin
                H       <= ZERO;
                V       <= (vs_pend | vs_fall) ? ZERO : sat_inc(V);
                vs_pend <= 1'b0;
            end else begin
                H <= sat_inc(H);
                if (vs_fall)
                    vs_pend <= 1'b1;
            end
        end
    end

    // Horizontal measurement: line period between de rises, de-high run length.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt      <= ZERO;
            seen_rise <= 1'b0;
            h_total   <= ZERO;
            hact_cnt  <= ZERO;
            h_active  <= ZERO;
        end else begin
            if (de_rise) begin
                hcnt      <= ZERO;
                seen_rise <= 1'b1;
                if (seen_rise)
                    h_total <= sat_inc(hcnt);
            end else begin
                hcnt <= sat_inc(hcnt);
            end
            if (de_rise)
                hact_cnt <= ONE;
            else if (s_de)
                hact_cnt <= sat_inc(hact_cnt);
            if (de_fall)
                h_active <= hact_cnt;
        end
    end

    // Vertical measurement: hsync edges and active lines between vsync edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_cnt   <= ZERO;
            dr_cnt   <= ZERO;
            v_total  <= ZERO;
            v_active <= ZERO;
        end else if (vs_fall) begin
            v_total  <= vt_new;
            v_active <= dr_cnt;
            hs_cnt   <= ZERO;
            dr_cnt   <= de_rise ? ONE : ZERO;
        end else begin
            if (hs_fall)
                hs_cnt <= sat_inc(hs_cnt);
            if (de_rise)
                dr_cnt <= sat_inc(dr_cnt);
        end
    end

`ifdef SYNC_TIMING_RX_TIMEOUT_EN
    logic [DATA_W-1:0] wd;

    // Watchdog: clocks since the last de rise, sticking at full scale.
    always_ff @(posedge clk) begin
        if (!rst)
            wd <= ZERO;
        else if (de_rise)
            wd <= ZERO;
        else
            wd <= sat_inc(wd);
    end

    assign timeout = &wd;
`else
    assign timeout = 1'b0;
`endif

    // Lock tracker: compares each completed frame with the previous one at vsync.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= SEARCH;
            locked  <= 1'b0;
            snap_ht <= ZERO;
            snap_vt <= ZERO;
            snap_ha <= ZERO;
            snap_va <= ZERO;
        end else if (timeout) begin
            state  <= SEARCH;
            locked <= 1'b0;
        end else if (vs_fall) begin
            snap_ht <= h_total;
            snap_vt <= vt_new;
            snap_ha <= h_active;
            snap_va <= dr_cnt;
            case (state)
                SEARCH: begin
                    state  <= MEASURE;
                    locked <= 1'b0;
                end
                MEASURE: begin
                    if (frame_match) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!frame_match) begin
                        state  <= MEASURE;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_timing_rx.sv
// Bench for sync_timing_rx: directed video rasters drive the inputs; every
// de rise queues the expected line/frame markers, and a monitor checks them
// when line_start appears. Measurement and lock state are checked at frame ends.
module tb_sync_timing_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        de = 1'b0;
    logic [11:0] H, V, h_total, v_total, h_active, v_active;
    logic        line_start, frame_start, locked;

    sync_timing_rx dut (
        .clk        (clk),
        .rst        (rst),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .H          (H),
        .V          (V),
        .h_total    (h_total),
        .v_total    (v_total),
        .h_active   (h_active),
        .v_active   (v_active),
        .line_start (line_start),
        .frame_start(frame_start),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int v;
        int fs;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int nchk = 0;
    int nerr = 0;

    int vexp        = 0;
    bit vs_pend_m   = 1'b0;
    bit prev_vs     = 1'b1;
    bit prev_de     = 1'b0;
    int last_vs_cyc = -100;
    bit free_drop   = 1'b0;
    bit prev_ls     = 1'b0;
    bit prev_locked = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One pixel of stimulus; de rises push the expected marker values.
    task automatic drive_pix(input logic h, input logic v, input logic d);
        @(negedge clk);
        hsync = h;
        vsync = v;
        de    = d;
        if (prev_vs && !v) begin
            vs_pend_m   = 1'b1;
            last_vs_cyc = cyc;
        end
        if (!prev_de && d) begin
            exp_t e;
            if (vs_pend_m) begin
                vexp = 0;
                e.fs = 1;
            end else begin
                vexp = vexp + 1;
                e.fs = 0;
            end
            vs_pend_m = 1'b0;
            e.v   = vexp;
            e.cyc = cyc;
            q.push_back(e);
        end
        prev_vs = v;
        prev_de = d;
    endtask

    task automatic run_lines(input int ht, input int ha, input int hss, input int hsl,
                             input int va, input int vss, input int vsl,
                             input int l0, input int l1);
        for (int l = l0; l < l1; l++)
            for (int p = 0; p < ht; p++)
                drive_pix(!(p >= hss && p < hss + hsl),
                          !(l >= vss && l < vss + vsl),
                          (l < va && p < ha));
    endtask

    // 16 x 806 raster: 8 active clocks, 768 active lines, vsync lines 771..776.
    task automatic frame_b();
        run_lines(16, 8, 10, 2, 768, 771, 6, 0, 806);
    endtask

    // 1344-clock lines (1024 active, hsync 136) in a 4-line frame.
    task automatic frame_a();
        run_lines(1344, 1024, 1048, 136, 2, 2, 1, 0, 4);
    endtask

    // Small 10-line raster with 12 active clocks and 6 active lines.
    task automatic frame_c(input int ht, input int vss, input int vsl, input int l0, input int l1);
        run_lines(ht, 12, 14, 3, 6, vss, vsl, l0, l1);
    endtask

    task automatic do_reset(input bit rnd, input bit check);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rnd) begin
                hsync = 1'($urandom_range(0, 1));
                vsync = 1'($urandom_range(0, 1));
                de    = 1'($urandom_range(0, 1));
            end else begin
                hsync = 1'b1;
                vsync = 1'b1;
                de    = 1'b0;
            end
            @(negedge clk);
        end
        if (check) begin
            chk("reset_H", H, 0);
            chk("reset_V", V, 0);
            chk("reset_h_total", h_total, 0);
            chk("reset_v_total", v_total, 0);
            chk("reset_h_active", h_active, 0);
            chk("reset_v_active", v_active, 0);
            chk("reset_line_start", line_start, 0);
            chk("reset_frame_start", frame_start, 0);
            chk("reset_locked", locked, 0);
        end
        hsync = 1'b1;
        vsync = 1'b1;
        de    = 1'b0;
        rst   = 1'b1;
        vexp      = 0;
        vs_pend_m = 1'b0;
        prev_vs   = 1'b1;
        prev_de   = 1'b0;
        q.delete();
    endtask

    // Monitor: pops the scoreboard on each line_start and checks lock-change timing.
    always @(negedge clk) begin
        if (rst) begin
            if (line_start) begin
                chk("sb_has_entry", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    chk("line_V", V, mon_e.v);
                    chk("line_frame_start", frame_start, mon_e.fs);
                    chk("line_H_zero", H, 0);
                    chk("line_start_latency", cyc - mon_e.cyc, 2);
                end
            end else if (frame_start) begin
                chk("frame_start_alone", frame_start, 0);
            end
            if (prev_ls)
                chk("H_after_line_start", H, 1);
            if ((locked !== prev_locked) && !free_drop)
                chk("locked_change_latency", cyc - last_vs_cyc, 2);
        end
        prev_ls     = line_start;
        prev_locked = locked;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        // Reset with random inputs, then idle after release.
        do_reset(1'b1, 1'b1);
        repeat (3) drive_pix(1'b1, 1'b1, 1'b0);
        chk("idle_line_start", line_start, 0);
        chk("idle_frame_start", frame_start, 0);
        chk("idle_locked", locked, 0);
        chk("idle_V", V, 0);
        chk("idle_h_total", h_total, 0);
        chk("idle_v_total", v_total, 0);

        // Tall raster: vertical measurements after the second vsync.
        frame_b();
        frame_b();
        chk("b_h_total", h_total, 16);
        chk("b_h_active", h_active, 8);
        chk("b_v_total", v_total, 806);
        chk("b_v_active", v_active, 768);
        chk("b_locked_after_2", locked, 0);

        // Wide raster: 1344/1024 horizontal, lock on the third vsync.
        do_reset(1'b0, 1'b0);
        frame_a();
        chk("a_locked_after_1", locked, 0);
        frame_a();
        chk("a_h_total", h_total, 1344);
        chk("a_h_active", h_active, 1024);
        chk("a_v_total", v_total, 4);
        chk("a_v_active", v_active, 2);
        chk("a_locked_after_2", locked, 0);
        frame_a();
        chk("a_locked_after_3", locked, 1);

        // Small raster: lock, locked-stream positions, then a line-length change.
        do_reset(1'b0, 1'b0);
        repeat (3) frame_c(20, 7, 2, 0, 10);
        chk("c_locked", locked, 1);
        frame_c(20, 7, 2, 0, 10);
        chk("c_still_locked", locked, 1);
        frame_c(22, 7, 2, 0, 10);
        chk("c_change_h_total", h_total, 22);
        chk("c_change_unlocked", locked, 0);
        frame_c(22, 7, 2, 0, 10);
        chk("c_change_relocked", locked, 1);

        // Reset in mid-frame: partial counts restart, first vsync only measures.
        frame_c(22, 7, 2, 0, 4);
        do_reset(1'b0, 1'b0);
        frame_c(22, 7, 2, 4, 10);
        chk("mid_locked_after_1", locked, 0);
        chk("mid_v_total", v_total, 3);
        chk("mid_v_active", v_active, 2);
        frame_c(22, 7, 2, 0, 10);
        chk("mid_locked_after_2", locked, 0);
        frame_c(22, 7, 2, 0, 10);
        chk("mid_locked_after_3", locked, 1);

        // vsync edge and de rise in the same cycle start line 0.
        do_reset(1'b0, 1'b0);
        frame_c(20, 10, 0, 0, 10);
        frame_c(20, 0, 2, 0, 10);
        chk("coinc_v_total", v_total, 10);
        chk("coinc_v_active", v_active, 6);

        // Loss of de while locked.
        do_reset(1'b0, 1'b0);
        repeat (3) frame_c(20, 7, 2, 0, 10);
        chk("to_locked_before", locked, 1);
`ifdef SYNC_TIMING_RX_TIMEOUT_EN
        free_drop = 1'b1;
`endif
        repeat (5000) drive_pix(1'b1, 1'b1, 1'b0);
        chk("to_H_saturated", H, 4095);
`ifdef SYNC_TIMING_RX_TIMEOUT_EN
        chk("to_locked_dropped", locked, 0);
`else
        chk("to_locked_kept", locked, 1);
`endif

        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sync_timing_rx.md
SYNC_TIMING_RX -- requirements
Module: sync_timing_rx

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: pixel clock; the only clock.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port hsync, input, 1 bit: horizontal sync, active-low (idle high).
REQ-004 The block SHALL have port vsync, input, 1 bit: vertical sync, active-low (idle high).
REQ-005 The block SHALL have port de, input, 1 bit: data enable, high during active pixels.
REQ-006 The block SHALL have port H, output, 12 bits: recovered horizontal position; 0 at the first active pixel of a line.
REQ-007 The block SHALL have port V, output, 12 bits: recovered line index; 0 at the first active line of a frame.
REQ-008 The block SHALL have ports h_total and v_total, outputs, 12 bits each: measured clocks per line and measured lines per frame.
REQ-009 The block SHALL have ports h_active and v_active, outputs, 12 bits each: measured de-high clocks per line and measured active lines per frame.
REQ-010 The block SHALL have ports line_start and frame_start, outputs, 1 bit each: single-cycle pulses.
REQ-011 The block SHALL have port locked, output, 1 bit: high only while the state machine is in LOCKED.

Function
REQ-012 The block SHALL register hsync, vsync and de into stage s_*, then keep a one-cycle history s_*_d for edge detection.
- de_rise = s_de & ~s_de_d; de_fall = ~s_de & s_de_d; hs_fall and vs_fall are defined likewise on the falling edge.
REQ-013 On the cycle de_rise is detected, H SHALL load 0 and line_start SHALL pulse.
- On every other cycle, H SHALL increment, saturating at 4095.
- H=0 appears 2 clk after the de input first goes high.
REQ-014 V handling on de_rise:
- If a vs_fall occurred since the previous de_rise, V SHALL load 0 and frame_start SHALL pulse in the same cycle as line_start.
- Otherwise V SHALL increment, saturating at 4095.
REQ-015 If vs_fall and de_rise occur in the same cycle, the vsync event SHALL be processed first, so that de_rise starts line 0.
REQ-016 h_total measurement:
- A free-running cycle counter, saturating at 4095, SHALL count clocks between consecutive de_rise events.
- Its value, plus 1, SHALL be latched into h_total at each de_rise.
- The first de_rise after reset SHALL NOT update h_total.
REQ-017 h_active SHALL latch the de-high run length, in clocks, at each de_fall.
REQ-018 v_total SHALL latch the number of hs_fall events between consecutive vs_fall events, counting the hs_fall of the closing edge, at each vs_fall.
REQ-019 v_active SHALL latch the number of de_rise events since the previous vs_fall, at each vs_fall.
REQ-020 The state machine SHALL have states SEARCH, MEASURE and LOCKED.
- SEARCH->MEASURE on the first vs_fall.
- At each later vs_fall, the block SHALL compare the just-completed frame's {h_total, v_total, h_active, v_active} against the previous frame's snapshot, then update the snapshot.
- MEASURE->LOCKED if all four fields are equal; otherwise it SHALL stay in MEASURE.
- LOCKED->MEASURE on any mismatch.
REQ-021 locked SHALL change only in the clock cycle after a vs_fall (or on reset or timeout).
- Measurement outputs SHALL update regardless of state.

Reset
REQ-022 While rst=0 at a clk edge, the following outputs and internal counters SHALL clear to 0: H, V, h_total, v_total, h_active, v_active, line_start, frame_start and locked.
- The state SHALL return to SEARCH.
REQ-023 On reset, s_hs, s_hs_d, s_vs and s_vs_d SHALL initialise to 1, and s_de and s_de_d to 0, so that no edge is detected in the first cycle after release.
REQ-024 A reset asserted mid-frame SHALL discard all partial measurements; the first vs_fall after release SHALL only enter MEASURE.

Configuration
REQ-025 With macro SYNC_TIMING_RX_TIMEOUT_EN defined, a 12-bit watchdog SHALL count clocks since the last de_rise.
- When the watchdog saturates at 4095, the state SHALL return to SEARCH and locked SHALL drop on the next clk.
- With the macro undefined, no watchdog SHALL exist and loss of input SHALL leave the state unchanged.

Verification
REQ-026 Reset scenario: hold rst=0 for 4 clk with random inputs, then release with idle inputs -> all outputs are 0, no pulses, and locked=0.
REQ-027 1024x768 timing scenario (1344x806 total, de for H 0..1023, V 0..767; hsync low 136 clk; vsync low 6 lines):
- After the 2nd vs_fall: h_total=1344, h_active=1024, v_total=806, v_active=768.
- locked=1 after the 3rd vs_fall.
REQ-028 Position scenario: in a locked stream, at the 2nd clk after the de input rises on the first active line -> H=0, V=0, line_start=frame_start=1; on the next line V=1 and frame_start=0.
REQ-029 Timing-change scenario: switch the locked stream to h_total=1346 -> locked falls 1 clk after the next vs_fall, then rises 1 clk after the following vs_fall.
REQ-030 Edge-coincidence scenario: drive vs_fall and de_rise in the same cycle -> V=0 and frame_start pulses on that line.
REQ-031 Timeout scenario (SYNC_TIMING_RX_TIMEOUT_EN defined): stop de for 5000 clk while locked -> locked=0 and the state is SEARCH by clk 4097 after the last de_rise; with the macro undefined, locked stays 1.
